// File: rtl/mixer_nch.sv
// mixer_nch: N-channel stereo mixer for the DAC path.
// On each L/R request from the DAC driver it pops one sample per channel,
// scales each by its per-side volume (Q.8), sums them and returns the
// saturated result with a one-cycle ack and sticky per-side clip flags.
module mixer_nch #(
    parameter int NUM_CH      = 4,
    parameter int NUM_CH_LOG2 = 2,
    parameter int DATA_W      = 24,
    parameter int VOL_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [NUM_CH*2-1:0]          pop_o,
    input  logic [NUM_CH*DATA_W-1:0]     data_i,
    input  logic [NUM_CH*2*VOL_W-1:0]    vol_i,
    input  logic [NUM_CH-1:0]            ch_en_i,
    input  logic [1:0]                   pop_i,
    output logic signed [DATA_W-1:0]     data_o,
    output logic [1:0]                   ack_o,
    output logic [1:0]                   clip_o,
    input  logic                         clip_clr_i
);

    localparam int PROD_W = DATA_W + VOL_W + 1;
    localparam int ACC_W  = PROD_W + NUM_CH_LOG2;
    localparam int RES_W  = ACC_W - 8;

    localparam logic [NUM_CH_LOG2-1:0] SLOT_ONE   = NUM_CH_LOG2'(1);
    localparam logic [NUM_CH_LOG2-1:0] LAST_SLOT  = NUM_CH_LOG2'(NUM_CH - 1);
    // Two drain cycles cover the product and accumulate registers.
    localparam logic [NUM_CH_LOG2-1:0] DRAIN_LAST = NUM_CH_LOG2'(1);

    localparam logic signed [RES_W-1:0] RES_MAX =
        {{(RES_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RES_W-1:0] RES_MIN = ~RES_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Drop the 8 fractional volume bits; arithmetic shift floors toward -inf.
    function automatic logic signed [RES_W-1:0] scale_down(input logic signed [ACC_W-1:0] acc);
        return RES_W'(acc >>> 8);
    endfunction

    function automatic logic is_clip(input logic signed [RES_W-1:0] res);
        return (res > RES_MAX) || (res < RES_MIN);
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [RES_W-1:0] res);
        if (res > RES_MAX) begin
            return RES_MAX[DATA_W-1:0];
        end else if (res < RES_MIN) begin
            return RES_MIN[DATA_W-1:0];
        end else begin
            return res[DATA_W-1:0];
        end
    endfunction

    // Sequencer / output state
    state_t                    state_q, state_d;
    logic [NUM_CH_LOG2-1:0]    slot_q, slot_d;
    logic                      side_q, side_d;
    logic [1:0]                pend_q, pend_d;
    logic [NUM_CH*2-1:0]       pop_q, pop_d;
    logic [1:0]                ack_q, ack_d;
    logic signed [DATA_W-1:0]  data_q, data_d;
    logic [1:0]                clip_q, clip_d;
    logic                      issue_go;
    logic [NUM_CH_LOG2-1:0]    issue_ch;
    logic signed [RES_W-1:0]   res;

    // Pipeline state
    logic                      vld_p0_q, vld_p0_d;
    logic                      en_p0_q, en_p0_d;
    logic                      first_p0_q, first_p0_d;
    logic [NUM_CH_LOG2-1:0]    ch_p0_q, ch_p0_d;
    logic                      vld_p1_q, vld_p1_d;
    logic                      first_p1_q, first_p1_d;
    logic signed [PROD_W-1:0]  prod_p1_q, prod_p1_d;
    logic signed [ACC_W-1:0]   acc_p2_q, acc_p2_d;
    logic signed [DATA_W-1:0]  smp_s;
    logic [VOL_W-1:0]          vol_u;
    logic signed [VOL_W:0]     vol_s;

    // Request capture, slot sequencing and output registration.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        side_d   = side_q;
        pend_d   = pend_q | pop_i;
        pop_d    = '0;
        ack_d    = '0;
        data_d   = data_q;
        clip_d   = clip_q;
        issue_go = 1'b0;
        issue_ch = '0;
        res      = scale_down(acc_p2_q);
        if (clip_clr_i) begin
            clip_d = '0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (|pend_d) begin
                    side_d   = ~pend_d[0];
                    state_d  = S_ISSUE;
                    slot_d   = '0;
                    issue_go = 1'b1;
                    issue_ch = '0;
                end
            end
            S_ISSUE: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = S_DRAIN;
                    slot_d  = '0;
                end else begin
                    slot_d   = slot_q + SLOT_ONE;
                    issue_go = 1'b1;
                    issue_ch = slot_q + SLOT_ONE;
                end
            end
            S_DRAIN: begin
                if (slot_q == DRAIN_LAST) begin
                    state_d = S_OUT;
                end else begin
                    slot_d = slot_q + SLOT_ONE;
                end
            end
            S_OUT: begin
                data_d         = saturate(res);
                ack_d[side_q]  = 1'b1;
                if (is_clip(res)) begin
                    clip_d[side_q] = 1'b1;
                end
                // The active side stays pending until here, so repeats are dropped.
                pend_d[side_q] = 1'b0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            pop_d[2*c]   = issue_go && ch_en_i[c] && (issue_ch == NUM_CH_LOG2'(c)) && !side_d;
            pop_d[2*c+1] = issue_go && ch_en_i[c] && (issue_ch == NUM_CH_LOG2'(c)) &&  side_d;
        end
    end

    // Slot tag travels with the sample; the enable is taken from the pop actually issued.
    always_comb begin
        vld_p0_d   = (state_q == S_ISSUE);
        first_p0_d = (slot_q == '0);
        ch_p0_d    = slot_q;
        en_p0_d    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (slot_q == NUM_CH_LOG2'(c)) begin
                en_p0_d = side_q ? pop_q[2*c+1] : pop_q[2*c];
            end
        end
    end

    // Product and accumulate datapath.
    always_comb begin
        smp_s      = data_i[int'(ch_p0_q)*DATA_W +: DATA_W];
        vol_u      = vol_i[(2*int'(ch_p0_q) + int'(side_q))*VOL_W +: VOL_W];
        vol_s      = {1'b0, vol_u};
        vld_p1_d   = vld_p0_q;
        first_p1_d = first_p0_q;
        if (en_p0_q) begin
            prod_p1_d = PROD_W'(smp_s) * PROD_W'(vol_s);
        end else begin
            prod_p1_d = '0;
        end
        acc_p2_d = acc_p2_q;
        if (vld_p1_q) begin
            if (first_p1_q) begin
                acc_p2_d = ACC_W'(prod_p1_q);
            end else begin
                acc_p2_d = acc_p2_q + ACC_W'(prod_p1_q);
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            side_q   <= 1'b0;
            pend_q   <= '0;
            pop_q    <= '0;
            ack_q    <= '0;
            data_q   <= '0;
            clip_q   <= '0;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            acc_p2_q <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            side_q   <= side_d;
            pend_q   <= pend_d;
            pop_q    <= pop_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            clip_q   <= clip_d;
            vld_p0_q <= vld_p0_d;
            vld_p1_q <= vld_p1_d;
            acc_p2_q <= acc_p2_d;
        end
    end

    // Pipeline payload registers; qualified by the valid bits above.
    always_ff @(posedge clk) begin
        // stage p0: slot tag aligned with returning sample
        en_p0_q    <= en_p0_d;
        first_p0_q <= first_p0_d;
        ch_p0_q    <= ch_p0_d;
        // stage p1: scaled product
        first_p1_q <= first_p1_d;
        prod_p1_q  <= prod_p1_d;
    end

    assign pop_o  = pop_q;
    assign ack_o  = ack_q;
    assign data_o = data_q;
    assign clip_o = clip_q;

endmodule

// File: doc/mixer_nch.md
Name: mixer_nch

Overview:
- Parametrised successor to the single-channel stereo mixer in the DAC path; runs on clk245760 (port clk).
- On each L/R pop request from the DAC driver, pops one sample from each resampled input channel.
- Scales each sample by its per-channel, per-side volume and accumulates the channels.
- Outputs the saturated sum, with per-channel enable and sticky clip flags.

Parameters:
- NUM_CH, 4, number of stereo input channels (>=1).
- NUM_CH_LOG2, 2, ceil(log2(NUM_CH)), minimum 1; accumulator guard bits.
- DATA_W, 24, signed sample width in and out.
- VOL_W, 16, unsigned volume width; Q(VOL_W-8).8, so 0x0100 = unity.

Ports:
- clk  in  1  mixer clock.
- rst  in  1  synchronous active-high reset.
- pop_o  out  NUM_CH*2  pop strobe to channel inputs; bit 2*ch+side, side 0=L, 1=R.
- data_i  in  NUM_CH*DATA_W  channel samples; ch0 in LSB slice; valid exactly 1 clk after the matching pop_o bit (no ack_i).
- vol_i  in  NUM_CH*2*VOL_W  volumes; slice index 2*ch+side.
- ch_en_i  in  NUM_CH  channel enable.
- pop_i  in  2  request from DAC driver; bit0=L, bit1=R.
- data_o  out  DATA_W  mixed sample.
- ack_o  out  2  1-clk strobe marking data_o valid for that side.
- clip_o  out  2  sticky saturation flag per side.
- clip_clr_i  in  1  clears clip_o.

Behaviour:
Reset:
- pop_o=0, ack_o=0, data_o=0, clip_o=0, pending requests cleared, sequencer idle, accumulator 0.
- Reset asserted mid-operation aborts the pass: no ack_o for it, and no pop_o in the cycle after rst falls.

Request capture:
- Per-side pending bit, set on pop_i[side].
- A pop_i on a side that is already pending or active is dropped; one pending request per side.
- If both sides are requested together, L is served first, then R.

Sequencer (IDLE, ISSUE, DRAIN, OUT):
- IDLE: if any request is pending, pick the side (L priority) and enter ISSUE.
- ISSUE: slot counter 0..NUM_CH-1, one channel per cycle. pop_o[2*ch+side] is high for 1 clk only if ch_en_i[ch]; a disabled channel uses its slot and contributes 0.
- DRAIN: wait for the multiply/accumulate pipeline to empty.
- OUT: register the result, pulse ack_o[side], clear that side's pending bit, return to IDLE.

Pipeline:
- Product stage: product = signed data_i slice (DATA_W) x {0, vol} (VOL_W+1 signed), registered. The enable bit is carried with the slot.
- Accumulate stage: accumulator of width DATA_W+VOL_W+1+NUM_CH_LOG2 is cleared at slot 0 and adds each product.

Latency:
- If pop_i is sampled at cycle t with the sequencer idle: pop_o for ch i at t+1+i, and ack_o at t+NUM_CH+4.
- A second request starts issuing the cycle after the first ack_o. Sustained throughput is one side per NUM_CH+4 clks.

Output arithmetic:
- res = acc >>> 8 (arithmetic shift, truncation toward -inf).
- If res > 2^(DATA_W-1)-1, output the max value and set clip_o[side]; if res < -2^(DATA_W-1), output the min value and set clip_o[side].
- data_o holds its value between acks.

Clip flags:
- clip_clr_i clears both flags.
- A saturation in the same cycle as clip_clr_i wins, so the flag stays set.

Test Plan:
- NUM_CH=4, all enabled, vol=0x0100, ch data L = 100, 200, 300, 400; pop_i=01 at t -> pop_o bits 0, 2, 4, 6 at t+1..t+4, ack_o=01 at t+8, data_o=1000, clip_o=00.
- vol L ch0=0x0080, data=-3 -> -1.5 truncates to data_o=-2. vol=0x0000 on all channels -> data_o=0.
- Four channels at 0x7FFFFF with vol=0x0100 on R -> data_o=0x7FFFFF, clip_o=10. clip_clr_i pulse -> clip_o=00. Repeat with 0x800000 -> data_o=0x800000.
- pop_i=11 in one cycle -> L pass completes with ack_o=01, then R pops start the next cycle and ack_o=10 arrives 8 clks after the L ack. A pop_i=01 during the L pass is dropped (only one L ack).
- ch_en_i=0101 -> pop_o never asserts for ch1/ch3; their data_i is ignored; ack timing is unchanged (t+8).
- rst asserted during ISSUE -> all outputs 0 the next cycle, no ack_o. After release a fresh pop_i produces a correct sum.
